// File: rtl/operand_history_buffer_if.sv
// Bundle between operand entry logic / ALU input mux and the operand history buffer.
// The master side drives the keypad-style controls; the slave side (the buffer) drives the read-back.
interface operand_history_buffer_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] op_in;
  logic             enter;
  logic             recall;
  logic             clear;
  logic [WIDTH-1:0] last_op;
  logic [WIDTH-1:0] op_out;
  logic [CW-1:0]    count;
  logic [PW-1:0]    recall_idx;
  logic             full;

  modport master (
    output op_in, enter, recall, clear,
    input  last_op, op_out, count, recall_idx, full
  );

  modport slave (
    input  op_in, enter, recall, clear,
    output last_op, op_out, count, recall_idx, full
  );
endinterface

// File: rtl/operand_history_buffer.sv
// Circular history of the last DEPTH committed operands with a wrap-around recall cursor.
// Outputs are decoded from registered state only; enter/recall are edge-detected level inputs.
module operand_history_buffer #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input logic                      clk,
  input logic                      nrst,
  operand_history_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = PW + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    cursor_q, cursor_d;
  logic             enter_q, recall_q;
  logic             enter_p_s, recall_p_s;
  logic             push_s;
  logic [PW-1:0]    newest_idx_s, recall_mem_idx_s;

  // Age 0 is the slot just behind the write pointer; the sum never exceeds 2*DEPTH-2, so one subtract wraps it.
  function automatic logic [PW-1:0] age_to_idx(input logic [PW-1:0] wp, input logic [PW-1:0] age);
    logic [IW-1:0] sum;
    sum = IW'(wp) + IW'(DEPTH - 1) - IW'(age);
    if (sum >= IW'(DEPTH)) begin
      age_to_idx = PW'(sum - IW'(DEPTH));
    end else begin
      age_to_idx = PW'(sum);
    end
  endfunction

  assign enter_p_s  = bus.enter  & ~enter_q;
  assign recall_p_s = bus.recall & ~recall_q;

  // Next-state decode with clear > enter > recall; losing pulses are dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cursor_d = cursor_q;
    push_s   = 1'b0;
    if (bus.clear) begin
      count_d  = {CW{1'b0}};
      cursor_d = {PW{1'b0}};
    end else if (enter_p_s) begin
      push_s   = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      count_d  = (count_q == CNT_FULL) ? count_q : count_q + CW'(1);
      cursor_d = {PW{1'b0}};
    end else if (recall_p_s) begin
      if (count_q != {CW{1'b0}}) begin
        cursor_d = (CW'(cursor_q) == count_q - CW'(1)) ? {PW{1'b0}} : cursor_q + PW'(1);
      end else begin
        cursor_d = cursor_q;
      end
    end else begin
      cursor_d = cursor_q;
    end
  end

  // Control state and edge-detect history.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      cursor_q <= {PW{1'b0}};
      enter_q  <= 1'b0;
      recall_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cursor_q <= cursor_d;
      enter_q  <= bus.enter;
      recall_q <= bus.recall;
    end
  end

  // Operand storage; op_in is only captured on a winning enter pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= bus.op_in;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign newest_idx_s     = age_to_idx(wr_ptr_q, {PW{1'b0}});
  assign recall_mem_idx_s = age_to_idx(wr_ptr_q, cursor_q);

  // Stale storage after a clear is masked by the empty check.
  assign bus.last_op    = (count_q == {CW{1'b0}}) ? {WIDTH{1'b0}} : mem_q[newest_idx_s];
  assign bus.op_out     = (count_q == {CW{1'b0}}) ? {WIDTH{1'b0}} : mem_q[recall_mem_idx_s];
  assign bus.count      = count_q;
  assign bus.recall_idx = cursor_q;
  assign bus.full       = (count_q == CNT_FULL);
endmodule
